// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: access sizes,
// controller states and the alignment rule used to reject bad accesses.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Size 11 is never legal; halves need an even address, words a 4-byte aligned one.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Little-endian lane handling: extracts and extends a load lane from a memory
// word, and splices store data into the target lane of a memory word.
module lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] i_mem_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mask;
    logic [31:0] w_lane_data;

    assign w_byte_sh = i_mem_word >> {i_offset, 3'b000};
    assign w_half_sh = i_mem_word >> {i_offset[1], 4'b0000};
    assign w_byte    = w_byte_sh[7:0];
    assign w_half    = w_half_sh[15:0];

    always_comb begin
        o_load_data = '0;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SZ_HALF: o_load_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            SZ_WORD: o_load_data = i_mem_word;
            default: o_load_data = '0;
        endcase
    end

    // Store data is replicated across every lane so the mask alone picks the target.
    always_comb begin
        w_mask      = '0;
        w_lane_data = '0;
        case (i_size)
            SZ_BYTE: begin
                w_mask      = 32'h0000_00FF << {i_offset, 3'b000};
                w_lane_data = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_mask      = 32'h0000_FFFF << {i_offset[1], 4'b0000};
                w_lane_data = {2{i_wdata[15:0]}};
            end
            SZ_WORD: begin
                w_mask      = 32'hFFFF_FFFF;
                w_lane_data = i_wdata;
            end
            default: begin
                w_mask      = '0;
                w_lane_data = '0;
            end
        endcase
    end

    assign o_merged = (i_mem_word & ~w_mask) | (w_lane_data & w_mask);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between a single requester and a registered-read data memory;
// sub-word stores are done as read-modify-write.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_word_addr;
    logic [1:0]        r_offset;
    logic [1:0]        r_size;
    logic              r_we;
    logic              r_unsigned;
    logic              r_err;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem_din;
    logic              w_accept;
    logic              w_bad;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    assign w_accept = req_valid && req_ready;
    assign w_bad    = is_bad_access(req_size, req_addr[1:0]);

    lsu_align u_align (
        .i_mem_word  (mem_dout),
        .i_wdata     (r_wdata),
        .i_size      (r_size),
        .i_offset    (r_offset),
        .i_unsigned  (r_unsigned),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_bad)
                        w_next = ST_RESP;
                    else if (req_we && req_size == SZ_WORD)
                        w_next = ST_WRITE;
                    else
                        w_next = ST_READ;
                end
            end
            ST_READ:  w_next = ST_MERGE;
            ST_MERGE: w_next = r_we ? ST_WRITE : ST_RESP;
            ST_WRITE: w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_word_addr <= '0;
            r_offset    <= '0;
            r_size      <= '0;
            r_we        <= 1'b0;
            r_unsigned  <= 1'b0;
            r_err       <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_mem_din   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_word_addr <= req_addr[ADDR_W+1:2];
                r_offset    <= req_addr[1:0];
                r_size      <= req_size;
                r_we        <= req_we;
                r_unsigned  <= req_unsigned;
                r_err       <= w_bad;
                r_wdata     <= req_wdata;
                r_rdata     <= '0;
                // Whole-word stores skip MERGE, so their write data is ready at accept.
                if (req_we && req_size == SZ_WORD && !w_bad)
                    r_mem_din <= req_wdata;
            end
            if (r_state == ST_MERGE) begin
                if (r_we)
                    r_mem_din <= w_merged;
                else
                    r_rdata <= w_load_data;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = (r_state == ST_RESP) && r_err;
    assign rsp_rdata = (r_state == ST_RESP && !r_we && !r_err) ? r_rdata : '0;
    assign mem_addr  = r_word_addr;
    assign mem_we    = (r_state == ST_WRITE);
    assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a registered-read memory model.
module tb_dmem_lsu;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout = '0;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              preWe = 1'b0;
    logic [ADDR_W-1:0] preAddr = '0;
    logic [31:0]       preData = '0;

    int vectors = 0;
    int miscompares = 0;
    int weCount = 0;
    int rspCount = 0;

    dmem_lsu #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle registered read; also counts write pulses and responses.
    always @(posedge clk) begin
        if (preWe)
            mem[preAddr] <= preData;
        else if (mem_we)
            mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
        if (mem_we)
            weCount <= weCount + 1;
        if (rsp_valid)
            rspCount <= rspCount + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        preAddr = a;
        preData = d;
        preWe   = 1'b1;
        @(posedge clk); #1;
        preWe   = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [ADDR_W+1:0] addr, input logic [31:0] wdata);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid    = 1'b0;
    endtask

    // Edges counted from the accept edge (=1) until rsp_valid is seen, then one more edge.
    task automatic waitRsp(output int edges, output logic [31:0] rd, output logic er,
                           output logic after);
        edges = 1;
        while (rsp_valid !== 1'b1 && edges < 12) begin
            @(posedge clk); #1;
            edges++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
        after = rsp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_err: got %b want 0", rsp_err); end
        vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h want 0", rsp_rdata); end
        vectors++; if (mem_addr !== 12'h0) begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
        vectors++; if (mem_din !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_din: got %h want 0", mem_din); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        logic [13:0] addrs [6] = '{14'h16, 14'h16, 14'h14, 14'h14, 14'h14, 14'h17};
        logic [1:0]  sizes [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00};
        logic        unss  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [6] = '{32'hFFFFFF99, 32'h00008899, 32'h8899AABB,
                                   32'h000000BB, 32'hFFFFAABB, 32'h00000088};
        int edges;
        logic [31:0] rd;
        logic er, after;
        int we0;
        for (int i = 0; i < 6; i++) begin
            we0 = weCount;
            issue(1'b0, sizes[i], unss[i], addrs[i], 32'hDEAD_BEEF);
            waitRsp(edges, rd, er, after);
            vectors++; if (edges != 3) begin miscompares++; $display("[TB] FAIL load%0d_latency: got %0d want 3", i, edges); end
            vectors++; if (rd !== exps[i]) begin miscompares++; $display("[TB] FAIL load%0d_rdata: got %h want %h", i, rd, exps[i]); end
            vectors++; if (er !== 1'b0) begin miscompares++; $display("[TB] FAIL load%0d_err: got %b want 0", i, er); end
            vectors++; if (after !== 1'b0) begin miscompares++; $display("[TB] FAIL load%0d_pulse: rsp_valid still %b want 0", i, after); end
            vectors++; if (weCount != we0) begin miscompares++; $display("[TB] FAIL load%0d_no_write: got %0d writes want 0", i, weCount - we0); end
            vectors++; if (mem_addr !== 12'd5) begin miscompares++; $display("[TB] FAIL load%0d_mem_addr: got %h want 5", i, mem_addr); end
        end
    endtask

    task automatic test_store();
        logic [13:0] addrs [3] = '{14'h15, 14'h16, 14'h14};
        logic [1:0]  sizes [3] = '{2'b00, 2'b01, 2'b10};
        logic [31:0] wds   [3] = '{32'hFFFF_FF11, 32'h1234_CAFE, 32'h1234_5678};
        int          lats  [3] = '{4, 4, 2};
        logic [31:0] exps  [3] = '{32'h889911BB, 32'hCAFE11BB, 32'h12345678};
        int edges;
        logic [31:0] rd;
        logic er, after;
        int we0;
        for (int i = 0; i < 3; i++) begin
            we0 = weCount;
            issue(1'b1, sizes[i], 1'b0, addrs[i], wds[i]);
            waitRsp(edges, rd, er, after);
            vectors++; if (edges != lats[i]) begin miscompares++; $display("[TB] FAIL store%0d_latency: got %0d want %0d", i, edges, lats[i]); end
            vectors++; if (weCount - we0 != 1) begin miscompares++; $display("[TB] FAIL store%0d_we_pulses: got %0d want 1", i, weCount - we0); end
            vectors++; if (mem[5] !== exps[i]) begin miscompares++; $display("[TB] FAIL store%0d_memword: got %h want %h", i, mem[5], exps[i]); end
            vectors++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("[TB] FAIL store%0d_rsp: rdata %h err %b want 0/0", i, rd, er); end
        end
    endtask

    task automatic test_error();
        logic [13:0] addrs [3] = '{14'h13, 14'h15, 14'h14};
        logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
        logic        wes   [3] = '{1'b1, 1'b0, 1'b1};
        int edges;
        logic [31:0] rd;
        logic er, after;
        int we0;
        for (int i = 0; i < 3; i++) begin
            we0 = weCount;
            issue(wes[i], sizes[i], 1'b0, addrs[i], 32'h5555_AAAA);
            waitRsp(edges, rd, er, after);
            vectors++; if (edges != 1) begin miscompares++; $display("[TB] FAIL err%0d_latency: got %0d want 1", i, edges); end
            vectors++; if (er !== 1'b1) begin miscompares++; $display("[TB] FAIL err%0d_flag: got %b want 1", i, er); end
            vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL err%0d_rdata: got %h want 0", i, rd); end
            vectors++; if (weCount != we0) begin miscompares++; $display("[TB] FAIL err%0d_no_write: got %0d writes want 0", i, weCount - we0); end
        end
        vectors++; if (mem[4] !== 32'h01020304) begin miscompares++; $display("[TB] FAIL err_mem4: got %h want 01020304", mem[4]); end
        vectors++; if (mem[5] !== 32'h12345678) begin miscompares++; $display("[TB] FAIL err_mem5: got %h want 12345678", mem[5]); end
    endtask

    task automatic test_reset_mid();
        int we0 = weCount;
        int rsp0 = rspCount;
        issue(1'b1, 2'b00, 1'b0, 14'h14, 32'h0000_0077);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_ready: got %b want 1", req_ready); end
        vectors++; if (mem_din !== 32'h0 || mem_addr !== 12'h0) begin miscompares++; $display("[TB] FAIL rstmid_mem_outs: din %h addr %h want 0/0", mem_din, mem_addr); end
        repeat (6) @(posedge clk);
        #1;
        vectors++; if (weCount != we0) begin miscompares++; $display("[TB] FAIL rstmid_no_write: got %0d writes want 0", weCount - we0); end
        vectors++; if (rspCount != rsp0) begin miscompares++; $display("[TB] FAIL rstmid_no_rsp: got %0d responses want 0", rspCount - rsp0); end
        vectors++; if (mem[5] !== 32'h12345678) begin miscompares++; $display("[TB] FAIL rstmid_mem5: got %h want 12345678", mem[5]); end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int nr = 0;
        int acc [2] = '{0, 0};
        int rsp [2] = '{0, 0};
        logic readyLog [0:16];
        logic rdy;
        int we0 = weCount;
        for (int k = 0; k <= 16; k++) readyLog[k] = 1'b1;
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 14'h20; req_wdata = 32'hA5A5_0001; req_valid = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            rdy = req_ready && req_valid;
            @(posedge clk); #1;
            readyLog[cyc] = req_ready;
            if (rdy) begin
                if (accepts < 2) acc[accepts] = cyc;
                accepts++;
                if (accepts == 1) begin
                    req_addr  = 14'h24;
                    req_wdata = 32'hA5A5_0002;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (rsp_valid) begin
                if (nr < 2) rsp[nr] = cyc;
                nr++;
            end
        end
        req_valid = 1'b0;
        vectors++; if (accepts != 2) begin miscompares++; $display("[TB] FAIL b2b_accepts: got %0d want 2", accepts); end
        vectors++; if (nr != 2) begin miscompares++; $display("[TB] FAIL b2b_responses: got %0d want 2", nr); end
        vectors++; if (acc[1] - acc[0] != 3) begin miscompares++; $display("[TB] FAIL b2b_accept_gap: got %0d want 3", acc[1] - acc[0]); end
        vectors++; if (rsp[1] - rsp[0] != 3) begin miscompares++; $display("[TB] FAIL b2b_rsp_gap: got %0d want 3", rsp[1] - rsp[0]); end
        vectors++; if (rsp[0] - acc[0] != 1) begin miscompares++; $display("[TB] FAIL b2b_latency: got %0d want 1", rsp[0] - acc[0]); end
        vectors++; if (readyLog[acc[0]] !== 1'b0 || readyLog[acc[0] + 1] !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy_ready: got %b%b want 00", readyLog[acc[0]], readyLog[acc[0] + 1]); end
        vectors++; if (weCount - we0 != 2) begin miscompares++; $display("[TB] FAIL b2b_writes: got %0d want 2", weCount - we0); end
        vectors++; if (mem[8] !== 32'hA5A50001 || mem[9] !== 32'hA5A50002) begin miscompares++; $display("[TB] FAIL b2b_mem: got %h %h want a5a50001 a5a50002", mem[8], mem[9]); end
    endtask

    initial begin
        $display("[TB] starting dmem_lsu bench");
        test_reset();
        preload(12'd5, 32'h8899AABB);
        preload(12'd4, 32'h01020304);
        @(posedge clk); #1;
        test_load();
        test_store();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning word-address width of the attached data memory.
REQ-002 SHALL have parameter DATA_W, default 32, meaning memory word width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  requester presents an access.
REQ-006 SHALL have port req_ready  output  1  block accepts an access this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-010 SHALL have port req_addr  input  ADDR_W+2  byte address; the word address is req_addr[ADDR_W+1:2].
REQ-011 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata  output  32  extended load data.
REQ-014 SHALL have port rsp_err  output  1  access was misaligned or illegal.
REQ-015 SHALL have port mem_addr  output  ADDR_W  word address to data memory.
REQ-016 SHALL have port mem_we  output  1  memory write enable.
REQ-017 SHALL have port mem_din  output  32  memory write data.
REQ-018 SHALL have port mem_dout  input  32  memory read data, registered, valid one cycle after mem_addr is presented.

Function
REQ-019 SHALL implement states IDLE, READ, MERGE, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 SHALL accept on the edge where req_valid && req_ready and capture all req_* fields; requests while busy are not accepted.
REQ-021 SHALL treat half with addr[0]=1, word with addr[1:0]!=0, or size 11 as errors: IDLE->RESP with rsp_err=1, no memory access.
REQ-022 SHALL sequence a load IDLE->READ->MERGE->RESP; rsp_valid is high 3 edges after accept.
REQ-023 SHALL sequence a word store IDLE->WRITE->RESP; rsp_valid is high 2 edges after accept.
REQ-024 SHALL sequence a byte/half store IDLE->READ->MERGE->WRITE->RESP (read-modify-write); rsp_valid is high 4 edges after accept.
REQ-025 SHALL drive mem_addr from the captured word address, holding it between accesses.
REQ-026 SHALL assert mem_we only in WRITE, for exactly one cycle per store.
REQ-027 SHALL use little-endian lanes: byte k = bits [8k+7:8k] with k = addr[1:0]; the half at addr[1] = bits [16*addr[1]+15:16*addr[1]].
REQ-028 SHALL, in MERGE, extract and extend the lane from mem_dout for loads, or replace only the target lane with req_wdata for stores, registering the result.
REQ-029 SHALL hold rsp_rdata valid with rsp_valid; it is 0 for stores and errors.
REQ-030 SHALL assert rsp_valid for exactly one cycle in RESP, then go to IDLE; the earliest next accept is the cycle after RESP.

Reset
REQ-031 SHALL, on rst at any edge including mid-access, enter IDLE, with rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_we=0, mem_din=0 from the following cycle; the abandoned access produces no response and no write.

Structure
REQ-032 SHALL take the size encodings and state enumeration from shared package dmem_lsu_pkg.
REQ-033 SHALL place lane extract/extend and lane merge in combinational sub-module lsu_align.

Verification
REQ-034 Preload word 5 = 0x8899AABB; load byte signed at addr 0x16 -> rsp_rdata 0xFFFFFF99 on the 3rd edge after accept, rsp_err 0.
REQ-035 Same word, load half unsigned at 0x16 -> 0x00008899; load word at 0x14 -> 0x8899AABB.
REQ-036 Store byte 0x11 at 0x15 -> exactly one mem_we pulse, and word 5 becomes 0x889911BB; rsp_valid on the 4th edge.
REQ-037 Store word at 0x13 -> rsp_err 1 on the 1st edge after accept, mem_we never asserted, memory unchanged.
REQ-038 Assert rst during MERGE of a byte store -> no mem_we, no rsp_valid, req_ready 1 the next cycle, memory unchanged.
REQ-039 Hold req_valid high with back-to-back word stores -> req_ready low while busy; each store is accepted once, and rsp_valid pulses are 3 cycles apart.
